pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It decides every cycle which pipeline latches (IF_ID, ID_EX, EX_MEM, MEM_WB) capture, hold, or load a bubble, and gates the PC. The decision comes from cache hits, load-use hazards, resolved branches/jumps and halt. It also runs the halt drain sequence and keeps a stall-cycle counter for performance debug.

---
 rtl/pipeline_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the five-stage pipeline.
// It decides each cycle which pipeline latches capture, hold or take a
// bubble, and it gates the PC. The decision comes from cache hits,
// load-use hazards, taken branches/jumps and halt. The block also runs
// the halt drain sequence and keeps a saturating stall-cycle counter.
//
// Ports:
//   CLK, nRST                      clock (rising edge), async active-low reset
//   ihit, dhit                     fetch / data access completed this cycle
//   mem_dREN, mem_dWEN             MEM-stage data read / write request
//   ex_dREN, ex_wsel               load in EX and its destination register
//   id_rs, id_rt, id_uses_rt       ID source registers, rt actually read
//   ex_branch_taken, id_jump       taken branch/jr in EX, J/JAL in ID
//   mem_halt                       halt instruction in MEM
//   pc_en, *_en                    PC / pipeline latch capture enables
//   *_flush                        load a bubble (only meaningful with _en)
//   halt_out                       processor halted
//   stall_cnt                      saturating count of pc_en=0 cycles
module pipeline_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_wsel,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic dreq;
    logic luse;
    logic decode;    // apply the normal hazard/branch/jump decode this cycle
    logic fetch_ok;  // ihit as seen by that decode

    assign dreq = mem_dREN | mem_dWEN;
    assign luse = ex_dREN && (ex_wsel != 5'd0) &&
                  ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            drain_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            RUN: begin
                if (mem_halt) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else if (dreq && !dhit) begin
                    state_d = DWAIT;
                end
            end
            DWAIT: begin
                if (dhit) state_d = RUN;
            end
            DRAIN: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == 3'(DRAIN_CYCLES - 1)) state_d = HALTED;
            end
            HALTED: state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Output logic
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halt_out    = 1'b0;
        decode      = 1'b0;
        fetch_ok    = ihit;

        unique case (state_q)
            RUN: begin
                if (mem_halt) begin
                    ifid_en     = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (!(dreq && !dhit)) begin
                    decode = 1'b1;
                end
            end
            DWAIT: begin
                // The release cycle decodes like RUN, but the fetch is
                // treated as complete regardless of ihit.
                if (dhit) begin
                    decode   = 1'b1;
                    fetch_ok = 1'b1;
                end
            end
            DRAIN: begin
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end
            HALTED: halt_out = 1'b1;
            default: ;
        endcase

        if (decode) begin
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (ex_branch_taken) begin
                // Squashes whatever sits in IF/ID, including a luse victim.
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (!fetch_ok || luse) begin
                idex_flush = 1'b1;
            end else begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = id_jump;
            end
        end
    end

    // Stall counter: saturating, only counts in RUN/DWAIT
    always_comb begin
        stall_d = stall_q;
        if ((state_q == RUN || state_q == DWAIT) && !pc_en && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic       CLK, nRST;
    logic       ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
    logic [4:0] ex_wsel, id_rs, id_rt;
    logic       id_uses_rt, ex_branch_taken, id_jump, mem_halt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, halt_out;
    logic [3:0] stall_cnt;

    pipeline_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
        .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
        .id_jump(id_jump), .mem_halt(mem_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halt_out(halt_out),
        .stall_cnt(stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem flush, halt_out}
    localparam logic [8:0] NORM  = 9'b11111_000_0;
    localparam logic [8:0] STALL = 9'b00111_010_0;
    localparam logic [8:0] BR    = 9'b11111_110_0;
    localparam logic [8:0] JMP   = 9'b11111_100_0;
    localparam logic [8:0] ZERO  = 9'b00000_000_0;
    localparam logic [8:0] DRN   = 9'b01111_111_0;
    localparam logic [8:0] HLT   = 9'b00000_000_1;

    typedef struct packed {
        logic [8:0] vec;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    logic [8:0] obs_vec;
    assign obs_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush, halt_out};

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        ex_dREN = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        id_uses_rt = 1'b0; ex_branch_taken = 1'b0; id_jump = 1'b0;
        mem_halt = 1'b0;
    endtask

    // Inputs are already driven (posedge+1). Push expectation, sample
    // at posedge+4, compare, then advance to the next posedge+1.
    task automatic step(input string tag, input logic [8:0] ev, input logic [3:0] ec);
        exp_t e;
        sb.push_back('{vec: ev, cnt: ec});
        #3;
        e = sb.pop_front();
        n_vec++;
        assert (obs_vec === e.vec) else begin
            n_fail++;
            $error("FAIL %s outputs: got %b want %b", tag, obs_vec, e.vec);
        end
        assert (stall_cnt === e.cnt) else begin
            n_fail++;
            $error("FAIL %s stall_cnt: got %0d want %0d", tag, stall_cnt, e.cnt);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        nRST = 1'b0;
        #1;
        // Under reset: outputs are the RUN decode, counter does not move
        ihit = 1'b0;           step("rst_stall_decode", STALL, 4'd0);
        ihit = 1'b1;           step("rst_norm", NORM, 4'd0);
        nRST = 1'b1;
        step("run_norm0", NORM, 4'd0);
        step("run_norm1", NORM, 4'd0);

        // Load-use on rs: exactly one bubble
        ex_dREN = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5;
        step("luse_rs", STALL, 4'd0);
        idle(); mem_dREN = 1'b1; dhit = 1'b1;
        step("luse_after", NORM, 4'd1);
        idle(); ex_dREN = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0;
        step("luse_r0", NORM, 4'd1);
        idle(); ex_dREN = 1'b1; ex_wsel = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
        step("luse_rt", STALL, 4'd1);
        id_uses_rt = 1'b0;
        step("luse_rt_unused", NORM, 4'd2);

        // Data miss: 3 cycles of full hold, release ignores ihit
        idle(); mem_dREN = 1'b1;
        step("dmiss_0", ZERO, 4'd2);
        step("dmiss_1", ZERO, 4'd3);
        step("dmiss_2", ZERO, 4'd4);
        dhit = 1'b1; ihit = 1'b0;
        step("dmiss_release", NORM, 4'd5);
        idle();
        step("dmiss_back_run", NORM, 4'd5);
        mem_dREN = 1'b1; dhit = 1'b1;
        step("dhit_same_cycle", NORM, 4'd5);
        idle();
        step("no_dwait", NORM, 4'd5);
        // Write miss, branch resolved in the release cycle
        mem_dWEN = 1'b1;
        step("wmiss", ZERO, 4'd5);
        dhit = 1'b1; ex_branch_taken = 1'b1;
        step("wmiss_release_br", BR, 4'd6);
        idle();
        step("after_wmiss", NORM, 4'd6);

        // Branch beats luse and jump
        ex_branch_taken = 1'b1; id_jump = 1'b1;
        ex_dREN = 1'b1; ex_wsel = 5'd3; id_rs = 5'd3;
        step("br_luse_jump", BR, 4'd6);
        idle(); id_jump = 1'b1;
        step("jump", JMP, 4'd6);
        idle(); ihit = 1'b0;
        step("imiss", STALL, 4'd6);

        // Halt with a fetch miss pending: halt wins
        mem_halt = 1'b1;
        step("halt_entry", DRN, 4'd7);
        idle();
        step("drain_0", DRN, 4'd8);
        step("drain_1", DRN, 4'd8);
        step("halted", HLT, 4'd8);
        ihit = 1'b0; dhit = 1'b1;
        step("halted_toggle_a", HLT, 4'd8);
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b1;
        step("halted_toggle_b", HLT, 4'd8);

        // Async reset out of HALTED
        idle(); nRST = 1'b0;
        step("rst_from_halt", NORM, 4'd0);
        nRST = 1'b1;
        step("run_after_rst", NORM, 4'd0);

        // Saturation at 15
        ihit = 1'b0;
        for (int i = 0; i < 20; i++)
            step("sat", STALL, (i > 15) ? 4'd15 : 4'(i));
        idle();
        step("sat_hold", NORM, 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
